// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-stream bundle for seq_pattern_tx.
// The requester drives start/data/reps. The transmitter returns status and the serial bit.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] reps;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, data, reps,
        input  ready, out, out_valid, busy, done
    );

    modport slave (
        input  start, data, reps,
        output ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. It shifts a captured WIDTH-bit pattern out MSB-first,
// repeating it reps times with GAP idle cycles between repetitions.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic            clk,
    input  logic            rst,
    seq_pattern_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   shadow;
    logic [BW-1:0]      bitcnt;
    logic [BW-1:0]      bit_idx;
    logic [CNT_W-1:0]   rep_left;
    logic               done_q;
    logic               bit_last;
    logic               gap_last;

    assign bit_last = (bitcnt == LAST_BIT);
    assign bit_idx  = LAST_BIT - bitcnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_n = state;
        unique case (state)
            S_IDLE:  if (bus.start && (bus.reps != '0)) state_n = S_SHIFT;
            S_SHIFT: if (bit_last) begin
                         if (rep_left == CNT_W'(1)) state_n = S_IDLE;
                         else if (GAP > 0)          state_n = S_GAP;
                         else                       state_n = S_SHIFT;
                     end
            S_GAP:   if (gap_last) state_n = S_SHIFT;
            default: state_n = S_IDLE;
        endcase
    end

    // Pattern shadow and counters. The shadow is cleared on reset so that a
    // stray index can never expose a previous request's bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            bitcnt   <= '0;
            rep_left <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: if (bus.start) begin
                    shadow   <= bus.data;
                    rep_left <= bus.reps;
                    bitcnt   <= '0;
                    done_q   <= (bus.reps == '0);
                end
                S_SHIFT: if (bit_last) begin
                    bitcnt   <= '0;
                    rep_left <= rep_left - CNT_W'(1);
                    done_q   <= (rep_left == CNT_W'(1));
                end else begin
                    bitcnt   <= bitcnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

    // The gap counter exists only in builds that insert idle cycles.
    if (GAP > 0) begin : g_gap
        logic [GW-1:0] gapcnt;
        always_ff @(posedge clk) begin
            if (rst)                 gapcnt <= '0;
            else if (state != S_GAP) gapcnt <= '0;
            else if (gap_last)       gapcnt <= '0;
            else                     gapcnt <= gapcnt + GW'(1);
        end
        assign gap_last = (gapcnt == GW'(GAP - 1));
    end else begin : g_nogap
        assign gap_last = 1'b1;
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.ready     = (state == S_IDLE);
        bus.busy      = (state != S_IDLE);
        bus.out_valid = (state == S_SHIFT);
        bus.out       = (state == S_SHIFT) && shadow[bit_idx];
        bus.done      = done_q;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: accepts a parallel WIDTH-bit pattern and a repeat count, then drives it MSB-first as a one-bit serial stream. Each bit lasts one clock, optionally with idle gaps between repetitions. It is the driving end of the team's single-bit serial sequence-detector interface (in/clk/rst/out). It replaces hand-written per-cycle stimulus with a synthesizable source usable on-board and in loopback benches.

Parameters:
WIDTH, 8, pattern length in bits (>=2)
CNT_W, 4, width of repeat-count input; max repetitions 2^CNT_W-1
GAP, 2, idle cycles between consecutive repetitions (0 = back-to-back)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted when start=1 and ready=1 at a rising edge
data  input  WIDTH  pattern, captured on accept; bit WIDTH-1 sent first
reps  input  CNT_W  number of repetitions, captured on accept
ready  output  1  block idle, can accept start
out  output  1  serial bit; 0 whenever out_valid=0
out_valid  output  1  out carries a pattern bit this cycle
busy  output  1  transmission (bits or gaps) in progress
done  output  1  one-cycle pulse when the request completes

Behaviour:
- Reset (rst=1 at edge): state IDLE, out=0, out_valid=0, busy=0, done=0, ready=1; shadow, bit and rep counters cleared. Overrides start in the same cycle. Mid-transfer reset aborts immediately; no done pulse.
- States: IDLE, SHIFT, GAP. All outputs registered or decoded from state only; no input-to-output combinational path.
- IDLE: ready=1, busy=0. On accept at edge k: shadow<=data, rep_left<=reps.
  - reps=0: stay IDLE, done=1 in cycle k+1, out_valid stays 0.
  - reps>0: go to SHIFT.
- SHIFT: out=shadow[WIDTH-1-bitcnt], out_valid=1, busy=1, ready=0. First bit in cycle k+1 (latency 1). bitcnt runs 0..WIDTH-1.
- After the last bit (bitcnt=WIDTH-1), rep_left decrements:
  - rep_left was 1: go to IDLE, done=1 and ready=1 in the next cycle.
  - else if GAP>0: go to GAP.
  - else: restart SHIFT at bitcnt=0 with no idle cycle.
- GAP: out=0, out_valid=0, busy=1, ready=0 for exactly GAP cycles, then SHIFT from bit WIDTH-1 of the same shadow.
- Timing for one request: duration = reps*WIDTH + (reps-1)*GAP cycles. done is asserted in cycle k+1+duration.
- done is high exactly 1 cycle, coincident with the first IDLE cycle. A start accepted in that cycle is legal; its first bit follows one cycle later.
- Inputs while busy: start ignored (no queueing). Changes to data/reps do not affect the stream in flight.
- Counters: bitcnt is ceil(log2 WIDTH) bits; rep_left is CNT_W bits, never underflows. Gap counter is sized for GAP; omit the GAP state logic when GAP=0.

Test Plan:
- Single pass: WIDTH=8, GAP=2, data=8'hD0, reps=1, accept at edge k -> out=1,1,0,1,0,0,0,0 with out_valid=1 in cycles k+1..k+8; cycle k+9 done=1, ready=1, out_valid=0.
- Repeat with gap: data=8'hB3, reps=2 -> bits 10110011 in k+1..k+8; out=0 and out_valid=0 in k+9..k+10; bits repeat in k+11..k+18; done in k+19 only.
- Zero reps / back-to-back: reps=0 -> done in k+1, out_valid never 1, busy never 1. GAP=0 build with reps=3, data=8'hD0 -> 24 contiguous valid bits, done in k+25.
- Ignore while busy: second start with data=8'hFF, reps=5 in cycle k+3 -> stream and done timing identical to the single-pass case. Start in the done cycle (k+9) is accepted, first bit in k+10.
- Reset mid-op: rst=1 in cycle k+4 of a reps=2 transfer -> next cycle out=0, out_valid=0, busy=0, ready=1, no done pulse. A fresh start afterwards transmits correctly from bit WIDTH-1.
- Loopback: data=8'b0001_1010, reps=1 fed into the team's 1101 sequence detector -> detector output asserts exactly once, aligned to the final '1' of 1101.
